// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: instruction fields,
// ALU operation codes, the FSM state set and the ALU-control selector.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation encodings driven on alu_opc
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // What the FSM asks of the ALU decoder in each state
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_IF,
        S_ID,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_EX,
        S_R_WB,
        S_I_EX,
        S_I_WB,
        S_BEQ_EX,
        S_J_EX
    } state_t;

endpackage

// File: rtl/alu_control.sv
// ALU decoder: turns the FSM's coarse request plus the R-type funct field
// into the concrete ALU operation, and flags whether funct is supported.
module alu_control
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_opc,
    output logic       funct_valid
);

    // Select the ALU operation; unsupported functs fall back to ADD.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        alu_opc     = ALU_ADD;
        funct_valid = 1'b0;
        case (funct)
            FN_ADD: funct_valid = 1'b1;
            FN_SUB: funct_valid = 1'b1;
            FN_AND: funct_valid = 1'b1;
            FN_OR:  funct_valid = 1'b1;
            FN_SLT: funct_valid = 1'b1;
            default: funct_valid = 1'b0;
        endcase
        case (alu_op)
            ALUOP_ADD: alu_opc = ALU_ADD;
            ALUOP_SUB: alu_opc = ALU_SUB;
            ALUOP_SLT: alu_opc = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alu_opc = ALU_SUB;
                    FN_AND:  alu_opc = ALU_AND;
                    FN_OR:   alu_opc = ALU_OR;
                    FN_SLT:  alu_opc = ALU_SLT;
                    default: alu_opc = ALU_ADD;
                endcase
            end
            default: alu_opc = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM. Outputs are Moore functions of the state and
// of opcode/funct latched in ID; only pc_en looks at the live zero flag.
// Reset forces IF asynchronously and masks every write/read strobe.
module multi_cycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_opc,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write
);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    alu_op_t    alu_op;
    logic       funct_valid;

    // Strobes as the state table defines them, before reset masking
    logic pc_write_st;
    logic ir_write_st;
    logic mem_read_st;
    logic mem_write_st;
    logic reg_write_st;

    alu_control u_alu_control (
        .alu_op      (alu_op),
        .funct       (funct_q),
        .alu_opc     (alu_opc),
        .funct_valid (funct_valid)
    );

    // State register; reset lands in IF immediately, abandoning any instruction.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= S_IF;
        else     state <= next_state;
    end

    // Capture the instruction fields in ID so later states decode from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            funct_q <= '0;
        end else if (state == S_ID) begin
            op_q    <= opcode;
            funct_q <= funct;
        end
    end

    // Next-state selection and per-state control values.
    always_comb begin
        next_state    = S_IF;
        alu_op        = ALUOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        pc_write_st   = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read_st   = 1'b0;
        mem_write_st  = 1'b0;
        ir_write_st   = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_st  = 1'b0;
        case (state)
            S_IF: begin
                mem_read_st = 1'b1;
                ir_write_st = 1'b1;
                alu_src_b   = 2'b01;
                pc_write_st = 1'b1;
                next_state  = S_ID;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:       next_state = S_R_EX;
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_BEQ:         next_state = S_BEQ_EX;
                    OP_J:           next_state = S_J_EX;
                    OP_ADDI,
                    OP_SLTI:        next_state = S_I_EX;
                    default:        next_state = S_IF;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_st = 1'b1;
                i_or_d      = 1'b1;
                next_state  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_st = 1'b1;
                mem_to_reg   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_st = 1'b1;
                i_or_d       = 1'b1;
            end
            S_R_EX: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                reg_dst      = 1'b1;
                reg_write_st = funct_valid;
            end
            S_I_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (op_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                reg_write_st = 1'b1;
            end
            S_BEQ_EX: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src        = 2'b01;
                pc_write_cond = 1'b1;
            end
            S_J_EX: begin
                pc_src      = 2'b10;
                pc_write_st = 1'b1;
            end
            default: next_state = S_IF;
        endcase
    end

    // Reset masks every strobe that could change architectural state.
    assign pc_write  = pc_write_st  & ~rst;
    assign ir_write  = ir_write_st  & ~rst;
    assign mem_read  = mem_read_st  & ~rst;
    assign mem_write = mem_write_st & ~rst;
    assign reg_write = reg_write_st & ~rst;
    assign pc_en     = ~rst & (pc_write_st | (pc_write_cond & zero));

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants in the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26]; stable from ID until return to IF.
REQ-005 funct  input  6  IR[5:0]; same stability as opcode.
REQ-006 zero  input  1  ALU zero flag (1 when ALU result == 0).
REQ-007 alu_opc  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed).
REQ-008 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  00 = B, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2.
REQ-010 pc_src  output  2  00 = ALU result, 01 = ALUOut register, 10 = {PC[31:28], IR[25:0], 2'b00}.
REQ-011 pc_write, pc_write_cond, pc_en  output  1 each  unconditional PC write, branch-qualified write, effective PC enable.
REQ-012 i_or_d, mem_read, mem_write, ir_write  output  1 each  memory address select (0 PC, 1 ALUOut), read strobe, write strobe, IR load.
REQ-013 reg_dst, mem_to_reg, reg_write  output  1 each  dest select (0 rt, 1 rd), write-back select (0 ALUOut, 1 MDR), register-file write.

Function
REQ-014 States: IF, ID, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BEQ_EX, J_EX; one transition per clock.
REQ-015 IF: mem_read=1, ir_write=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_opc=ADD, pc_src=00, pc_write=1; next ID.
REQ-016 ID: alu_src_a=0, alu_src_b=11, alu_opc=ADD (branch target precomputed into ALUOut); next by opcode: 000000 R_EX; 100011/101011 MEM_ADDR; 000100 BEQ_EX; 000010 J_EX; 001000/001010 I_EX; any other opcode IF (NOP).
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; next MEM_RD for lw, MEM_WR for sw.
REQ-018 MEM_RD: mem_read=1, i_or_d=1; next MEM_WB.  MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next IF.
REQ-019 MEM_WR: mem_write=1, i_or_d=1; next IF.
REQ-020 R_EX: alu_src_a=1, alu_src_b=00, alu_opc from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other ADD; next R_WB.
REQ-021 R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 only for the five supported functs (unsupported funct writes nothing); next IF.
REQ-022 I_EX: alu_src_a=1, alu_src_b=10, alu_opc ADD (addi) or SLT (slti); next I_WB.  I_WB: reg_dst=0, mem_to_reg=0, reg_write=1; next IF.
REQ-023 BEQ_EX: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write_cond=1; next IF.
REQ-024 J_EX: pc_src=10, pc_write=1; next IF.
REQ-025 pc_en = pc_write | (pc_write_cond & zero), combinational from zero in the same cycle; all other outputs are Moore (state and latched opcode/funct only).
REQ-026 Any output not listed for a state is 0 (alu_opc defaults to ADD).
REQ-027 Cycles per instruction, IF through last state: lw 5; sw, R-type, addi, slti 4; beq, j 3; unknown opcode 2.
REQ-028 At most one of mem_read/mem_write is high in any cycle; ir_write is high only in IF.

Reset
REQ-029 rst high forces state IF immediately, including mid-instruction; the in-flight instruction is abandoned with no further writes.
REQ-030 While rst is high, pc_write, pc_en, ir_write, mem_read, mem_write and reg_write are 0; other outputs take IF values.
REQ-031 First rising edge after rst deasserts executes IF.

Structure
REQ-032 Shared package mips_pkg holds opcode and funct constants, the ALU opcode encodings, and the state enumeration.
REQ-033 Sub-module alu_control maps (state-derived 2-bit alu_op, funct) to alu_opc and a funct_valid flag; the FSM instantiates it once.

Verification
REQ-034 R-type add (op 000000, funct 100000): IF,ID,R_EX,R_WB,IF; alu_opc=010 in R_EX; reg_write=1, reg_dst=1 only in R_WB.
REQ-035 lw (op 100011): 5-cycle sequence; i_or_d=1 and mem_read=1 in MEM_RD; mem_to_reg=1, reg_write=1 in MEM_WB.
REQ-036 beq (op 000100) with zero=1 -> pc_en=1 in BEQ_EX; with zero=0 -> pc_en=0; alu_opc=110 in both cases.
REQ-037 Unknown opcode 111111 -> ID returns to IF; no write strobe asserted; R-type funct 000000 -> reg_write stays 0 in R_WB.
REQ-038 rst asserted asynchronously during MEM_WR -> mem_write drops to 0 before the next edge; after release, state is IF and pc_write=1.
